// File: rtl/int_cond_pkg.sv
// Shared constants and types for the IRQ source conditioner: register offsets, line modes,
// APB FSM states and the word-count helper.
package int_cond_pkg;

  localparam int unsigned OFF_TYPE = 32'h000;
  localparam int unsigned OFF_POL  = 32'h020;
  localparam int unsigned OFF_PEND = 32'h040;
  localparam int unsigned OFF_CLR  = 32'h060;

  typedef enum logic {MODE_LEVEL = 1'b0, MODE_EDGE = 1'b1} mode_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} apb_state_e;

  function automatic int WORDS(input int n);
    return (n + 31) / 32;
  endfunction

endpackage

// File: rtl/int_cond_line.sv
// One IRQ line: synchroniser chain, one-cycle-delayed copy and polarity-selected edge detect.
// Latency: sync_o follows irq_i by SYNC_STAGES cycles; edge_o is combinational on the flops.
module int_cond_line #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_apb,
  input  logic rst_apb_n,
  input  logic irq_i,
  input  logic pol_i,
  output logic sync_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  // Detection works on the raw synchronised level, so reprogramming pol_i never fakes an edge.
  assign edge_o = pol_i ? (prev_q & ~sync_o) : (sync_o & ~prev_q);

endmodule

// File: rtl/int_source_conditioner.sv
// IRQ source conditioner: per-line level pass-through or sticky edge capture, programmed over APB.
// Latency: level SYNC_STAGES+1, edge SYNC_STAGES+2 cycles; APB always answers with one wait state.
module int_source_conditioner
  import int_cond_pkg::*;
#(
  parameter int NUM_SOURCES = 64,
  parameter int SYNC_STAGES = 2,
  parameter int APB_DW      = 32,
  parameter int APB_AW      = 12
) (
  input  logic                   clk_apb,
  input  logic                   rst_apb_n,
  input  logic [NUM_SOURCES-1:0] irq_in,
  output logic [NUM_SOURCES-1:0] int_raw,
  input  logic [APB_AW-1:0]      paddr,
  input  logic                   pwrite,
  input  logic [APB_DW-1:0]      pwdata,
  input  logic                   psel,
  input  logic                   penable,
  output logic [APB_DW-1:0]      prdata,
  output logic                   pready,
  output logic                   pslverr
);

  localparam int NW   = WORDS(NUM_SOURCES);
  localparam int WU_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0] WU_INIT = WU_W'(SYNC_STAGES + 1);

  localparam logic [APB_AW-1:0] A_TYPE = APB_AW'(OFF_TYPE);
  localparam logic [APB_AW-1:0] A_POL  = APB_AW'(OFF_POL);
  localparam logic [APB_AW-1:0] A_PEND = APB_AW'(OFF_PEND);
  localparam logic [APB_AW-1:0] A_CLR  = APB_AW'(OFF_CLR);

  logic [NUM_SOURCES-1:0] s, edge_det;
  logic [NUM_SOURCES-1:0] type_q, type_d, pol_q, pol_d, pend_q, pend_d;
  logic [NUM_SOURCES-1:0] int_raw_q, int_raw_d;
  logic [NUM_SOURCES-1:0] wmask, wval, clr, rsrc;
  logic [WU_W-1:0]        wu_q;
  logic                   warm_done;

  apb_state_e        state_q;
  logic              hold_q, pready_q, pslverr_q;
  logic [APB_DW-1:0] prdata_q, rdata_d;

  logic [2:0]        word;
  logic [APB_AW-6:0] grp;
  logic              hit_type, hit_pol, hit_pend, hit_clr;
  logic              addr_err, access, wr_ok;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_line
    int_cond_line #(.SYNC_STAGES(SYNC_STAGES)) u_line (
      .clk_apb  (clk_apb),
      .rst_apb_n(rst_apb_n),
      .irq_i    (irq_in[g]),
      .pol_i    (pol_q[g]),
      .sync_o   (s[g]),
      .edge_o   (edge_det[g])
    );
  end

  assign word     = paddr[4:2];
  assign grp      = paddr[APB_AW-1:5];
  assign hit_type = (grp == A_TYPE[APB_AW-1:5]);
  assign hit_pol  = (grp == A_POL[APB_AW-1:5]);
  assign hit_pend = (grp == A_PEND[APB_AW-1:5]);
  assign hit_clr  = (grp == A_CLR[APB_AW-1:5]);

  assign addr_err = (paddr[1:0] != 2'b00) || (int'(word) >= NW)
                  || !(hit_type || hit_pol || hit_pend || hit_clr)
                  || (pwrite && hit_pend);
  // hold_q blocks a second acceptance of the same transfer while penable stays high.
  assign access    = (state_q == ST_IDLE) && psel && penable && !hold_q;
  assign wr_ok     = access && pwrite && !addr_err;
  assign warm_done = (wu_q == '0);

  always_comb begin
    wmask   = '0;
    wval    = '0;
    rdata_d = '0;
    rsrc    = hit_type ? type_q : hit_pol ? pol_q : hit_pend ? pend_q : '0;
    for (int b = 0; b < NUM_SOURCES; b++) begin
      if (b / 32 == int'(word)) begin
        wmask[b]          = 1'b1;
        wval[b]           = pwdata[b % 32];
        rdata_d[b % 32]   = rsrc[b];
      end
    end

    type_d = type_q;
    pol_d  = pol_q;
    clr    = '0;
    if (wr_ok) begin
      if (hit_type) type_d = (type_q & ~wmask) | (wval & wmask);
      if (hit_pol)  pol_d  = (pol_q & ~wmask) | (wval & wmask);
      if (hit_clr)  clr    = wval & wmask;
    end

    // Set beats clear; masking with type_d drops PEND on any bit moving to level mode.
    pend_d = ((pend_q & ~clr) | (edge_det & type_q & {NUM_SOURCES{warm_done}})) & type_d;

    int_raw_d = '0;
    for (int b = 0; b < NUM_SOURCES; b++) begin
      int_raw_d[b] = (mode_e'(type_q[b]) == MODE_EDGE) ? pend_q[b] : (s[b] ^ pol_q[b]);
    end
  end

  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      type_q    <= '0;
      pol_q     <= '0;
      pend_q    <= '0;
      int_raw_q <= '0;
      wu_q      <= WU_INIT;
    end else begin
      type_q    <= type_d;
      pol_q     <= pol_d;
      pend_q    <= pend_d;
      int_raw_q <= int_raw_d;
      wu_q      <= warm_done ? wu_q : wu_q - 1'b1;
    end
  end

  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      if (!penable) hold_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            state_q   <= ST_RESP;
            hold_q    <= 1'b1;
            pready_q  <= 1'b1;
            pslverr_q <= addr_err;
            prdata_q  <= (addr_err || pwrite) ? '0 : rdata_d;
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_raw = int_raw_q;
  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_int_source_conditioner.sv
// Directed and randomised checks of the IRQ source conditioner with 40 sources.
module tb_int_source_conditioner;

  localparam int N  = 40;
  localparam int RN = 150;

  logic          clk_apb = 1'b0;
  logic          rst_apb_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic [N-1:0]  int_raw;
  logic [11:0]   paddr = '0;
  logic          pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] h [0:RN];
  logic [N-1:0] pm [0:RN];
  logic [N-1:0] ty, po, base, hx, px, e, expv;
  logic [63:0]  r64;
  logic [31:0]  rd;
  logic         er;

  int_source_conditioner #(
    .NUM_SOURCES(N), .SYNC_STAGES(2), .APB_DW(32), .APB_AW(12)
  ) dut (
    .clk_apb(clk_apb), .rst_apb_n(rst_apb_n), .irq_in(irq_in), .int_raw(int_raw),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk_apb = ~clk_apb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_apb);
  endtask

  // Returns on the negedge where pready is seen high.
  task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rdat, output logic err);
    int k;
    @(negedge clk_apb);
    paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
    @(negedge clk_apb);
    penable = 1'b1;
    for (k = 0; k < 8; k++) begin
      @(negedge clk_apb);
      if (pready === 1'b1) break;
    end
    if (k == 8) chk("pready_timeout", {63'b0, pready}, 64'd1);
    rdat = prdata; err = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e2;
    apb(a, 1'b1, d, r, e2);
    chk($sformatf("wr_%03h_err", a), {63'b0, e2}, 64'd0);
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e2;
    apb(a, 1'b0, 32'h0, r, e2);
    chk({tag, "_err"}, {63'b0, e2}, 64'd0);
    chk(tag, {32'b0, r}, {32'b0, exp});
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_int_raw", {24'b0, int_raw}, 64'd0);
    chk("rst_pready", {63'b0, pready}, 64'd0);
    chk("rst_pslverr", {63'b0, pslverr}, 64'd0);
    chk("rst_prdata", {32'b0, prdata}, 64'd0);
    rst_apb_n = 1'b1;
    cyc(5);

    // Level mode: three cycles each way
    irq_in[3] = 1'b1;
    cyc(2); chk("lvl_rise_c2", {63'b0, int_raw[3]}, 64'd0);
    cyc(1); chk("lvl_rise_c3", {63'b0, int_raw[3]}, 64'd1);
    irq_in[3] = 1'b0;
    cyc(2); chk("lvl_fall_c2", {63'b0, int_raw[3]}, 64'd1);
    cyc(1); chk("lvl_fall_c3", {63'b0, int_raw[3]}, 64'd0);

    // Edge mode: one-cycle pulse captured after four cycles, sticky, W1C
    wr(12'h000, 32'h1);
    cyc(3);
    irq_in[0] = 1'b1; cyc(1); irq_in[0] = 1'b0;
    cyc(2); chk("edge_c3", {63'b0, int_raw[0]}, 64'd0);
    cyc(1); chk("edge_c4", {63'b0, int_raw[0]}, 64'd1);
    cyc(6); chk("edge_sticky", {63'b0, int_raw[0]}, 64'd1);
    apb(12'h060, 1'b1, 32'h1, rd, er);
    chk("clr_err", {63'b0, er}, 64'd0);
    chk("clr_at_pready", {63'b0, int_raw[0]}, 64'd1);
    cyc(1);
    chk("clr_after_pready", {63'b0, int_raw[0]}, 64'd0);
    chk("pready_one_cycle", {63'b0, pready}, 64'd0);

    // Polarity change with line held high raises nothing; falling edge then counts
    irq_in[0] = 1'b1; cyc(6);
    wr(12'h060, 32'h1);
    wr(12'h020, 32'h1);
    cyc(6);
    rdchk("pol_no_spurious", 12'h040, 32'h0);
    irq_in[0] = 1'b0; cyc(6);
    rdchk("pol_fall_pend", 12'h040, 32'h1);
    wr(12'h060, 32'h1);
    wr(12'h020, 32'h0);
    cyc(3);
    rdchk("pol_restore_pend", 12'h040, 32'h0);

    // Set/clear race on bit 5: earlier edge is cleared, coincident edge survives
    wr(12'h000, 32'h21);
    irq_in[5] = 1'b1; cyc(1);
    wr(12'h060, 32'h20);
    rdchk("clr_after_set", 12'h040, 32'h0);
    irq_in[5] = 1'b0; cyc(4);
    irq_in[5] = 1'b1;
    wr(12'h060, 32'h20);
    rdchk("set_wins_clr", 12'h040, 32'h20);
    wr(12'h000, 32'h1);
    rdchk("to_level_clears", 12'h040, 32'h0);
    cyc(2);
    chk("bit5_level", {63'b0, int_raw[5]}, 64'd1);
    irq_in[5] = 1'b0;

    // Address decode and width boundary for 40 sources
    apb(12'h008, 1'b0, 32'h0, rd, er);
    chk("w2_rd_err", {63'b0, er}, 64'd1);
    chk("w2_rd_data", {32'b0, rd}, 64'd0);
    apb(12'h001, 1'b0, 32'h0, rd, er);
    chk("misalign_rd_err", {63'b0, er}, 64'd1);
    chk("misalign_rd_data", {32'b0, rd}, 64'd0);
    apb(12'h001, 1'b1, 32'h0, rd, er);
    chk("misalign_wr_err", {63'b0, er}, 64'd1);
    rdchk("misalign_no_write", 12'h000, 32'h1);
    apb(12'h040, 1'b1, 32'hFFFF_FFFF, rd, er);
    chk("pend_wr_err", {63'b0, er}, 64'd1);
    apb(12'h080, 1'b0, 32'h0, rd, er);
    chk("unmapped_err", {63'b0, er}, 64'd1);
    wr(12'h004, 32'hFFFF_FFFF);
    rdchk("type1_width", 12'h004, 32'h0000_00FF);
    rdchk("clr_reads_0", 12'h060, 32'h0);
    wr(12'h004, 32'h0);
    wr(12'h000, 32'h0);

    // Randomised: random modes, polarities and toggling lines against a delay/sticky model
    r64 = {$urandom, $urandom}; ty = r64[N-1:0];
    r64 = {$urandom, $urandom}; po = r64[N-1:0];
    r64 = {$urandom, $urandom}; base = r64[N-1:0];
    irq_in = base; cyc(6);
    r64 = {24'b0, ty};
    wr(12'h000, r64[31:0]); wr(12'h004, r64[63:32]);
    r64 = {24'b0, po};
    wr(12'h020, r64[31:0]); wr(12'h024, r64[63:32]);
    cyc(4);
    wr(12'h060, 32'hFFFF_FFFF); wr(12'h064, 32'h0000_00FF);
    cyc(3);
    h[0] = base; pm[0] = '0;
    for (int j = 1; j <= RN; j++) begin
      hx = (j >= 3) ? h[j-3] : base;
      px = (j >= 4) ? pm[j-4] : '0;
      expv = (ty & px) | (~ty & (hx ^ po));
      chk($sformatf("rand_c%0d", j), {24'b0, int_raw}, {24'b0, expv});
      e = '0;
      if (j < RN - 8) begin
        for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) e[b] = 1'b1;
      end
      h[j]  = h[j-1] ^ e;
      pm[j] = pm[j-1] | (po & h[j-1] & ~h[j]) | (~po & h[j] & ~h[j-1]);
      irq_in = h[j];
      cyc(1);
    end
    r64 = {24'b0, pm[RN] & ty};
    rdchk("rand_pend0", 12'h040, r64[31:0]);
    rdchk("rand_pend1", 12'h044, r64[63:32]);

    // Lines high through reset: warm-up keeps PEND clear
    irq_in = '1;
    rst_apb_n = 1'b0; cyc(3);
    chk("rst2_int_raw", {24'b0, int_raw}, 64'd0);
    chk("rst2_pready", {63'b0, pready}, 64'd0);
    rst_apb_n = 1'b1;
    wr(12'h000, 32'hFFFF_FFFF);
    wr(12'h004, 32'h0000_00FF);
    cyc(8);
    rdchk("warm_pend0", 12'h040, 32'h0);
    rdchk("warm_pend1", 12'h044, 32'h0);
    chk("warm_int_raw", {24'b0, int_raw}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
